// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS Avalon bus master.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // Raw size code 3 behaves as a word access.
  function automatic size_t decode_size(input logic [1:0] raw);
    return (raw == 2'd0) ? SZ_BYTE : (raw == 2'd1) ? SZ_HALF : SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input size_t size, input logic [1:0] offset);
    return (size == SZ_HALF) ? offset[0] : ((size == SZ_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/mips_bus_mem_ctrl_if.sv
// Avalon-MM port bundle between the bus master and the memory/interconnect.
interface mips_bus_mem_ctrl_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_lane_align.sv
// Little-endian byte-lane steering: store enables/replication and load extraction.
module mips_lane_align
  import mips_bus_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] readdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = 8'(readdata >> {offset, 3'b000});
  assign half_val = 16'(readdata >> {offset[1], 4'b0000});

  always_comb begin
    byteenable = BE_ALL;
    writedata  = store_data;
    load_data  = readdata;
    case (size)
      SZ_BYTE: begin
        byteenable = 4'b0001 << offset;
        writedata  = {4{store_data[7:0]}};
        load_data  = {{24{sign_ext & byte_val[7]}}, byte_val};
      end
      SZ_HALF: begin
        byteenable = offset[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{store_data[15:0]}};
        load_data  = {{16{sign_ext & half_val[15]}}, half_val};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mips_bus_mem_ctrl.sv
// Round-robin fetch/data arbiter driving one Avalon-MM master port with wait timeout.
// Define MEM_ALIGN_CHECK_EN to fault misaligned half/word accesses without a bus cycle.
module mips_bus_mem_ctrl
  import mips_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       if_req,
  input  logic [ADDR_W-1:0]          if_addr,
  output logic                       if_ack,
  output logic [31:0]                if_rdata,
  output logic                       if_err,
  input  logic                       d_req,
  input  logic                       d_we,
  input  logic [ADDR_W-1:0]          d_addr,
  input  logic [1:0]                 d_size,
  input  logic                       d_signed,
  input  logic [31:0]                d_wdata,
  output logic                       d_ack,
  output logic [31:0]                d_rdata,
  output logic                       d_err,
  mips_bus_mem_ctrl_if.master        bus,
  output logic                       busy
);

  localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  mem_state_t      state_q, state_d;
  logic            gnt_d_q, last_grant_q, we_q, sign_q, err_q;
  size_t           size_q;
  logic [1:0]      off_q;
  logic [31:0]     rdata_q;
  logic [CntW-1:0] waitcnt_q;
  logic            read_q, write_q;
  logic [31:0]     address_q, wdata_q;
  logic [3:0]      be_q;

  logic        req_any, take_d, sel_we, sel_sign, misalign, timeout;
  logic [31:0] sel_addr;
  size_t       sel_size, la_size;
  logic [1:0]  la_off;
  logic        la_sign;
  logic [3:0]  la_be;
  logic [31:0] la_wdata, la_load;

  // last_grant_q: 0 = fetch, 1 = data; a tie goes to the other channel.
  always_comb begin
    req_any  = if_req | d_req;
    take_d   = d_req & (~if_req | ~last_grant_q);
    sel_addr = take_d ? 32'(d_addr) : 32'(if_addr);
    sel_we   = take_d & d_we;
    sel_size = take_d ? decode_size(d_size) : SZ_WORD;
    sel_sign = take_d & d_signed;
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = is_misaligned(sel_size, sel_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign timeout = (MAX_WAIT != 0) && bus.waitrequest &&
                   ((32'(waitcnt_q) + 32'd1) == MAX_WAIT);

  // Shared lane logic: request fields while idle, latched fields once granted.
  assign la_size = (state_q == IDLE) ? sel_size : size_q;
  assign la_off  = (state_q == IDLE) ? sel_addr[1:0] : off_q;
  assign la_sign = (state_q == IDLE) ? sel_sign : sign_q;

  mips_lane_align u_lane_align (
    .size       (la_size),
    .offset     (la_off),
    .sign_ext   (la_sign),
    .store_data (d_wdata),
    .readdata   (bus.readdata),
    .byteenable (la_be),
    .writedata  (la_wdata),
    .load_data  (la_load)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_any) state_d = misalign ? RESP : BUS;
      BUS:     if (!bus.waitrequest || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_ack   = (state_q == RESP) & ~gnt_d_q;
    d_ack    = (state_q == RESP) & gnt_d_q;
    if_rdata = if_ack ? rdata_q : '0;
    d_rdata  = d_ack ? rdata_q : '0;
    if_err   = if_ack & err_q;
    d_err    = d_ack & err_q;
    busy     = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt_d_q      <= 1'b0;
      last_grant_q <= 1'b0;
      we_q         <= 1'b0;
      sign_q       <= 1'b0;
      err_q        <= 1'b0;
      size_q       <= SZ_WORD;
      off_q        <= '0;
      rdata_q      <= '0;
      waitcnt_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (req_any) begin
          gnt_d_q      <= take_d;
          last_grant_q <= take_d;
          we_q         <= sel_we;
          sign_q       <= sel_sign;
          size_q       <= sel_size;
          off_q        <= sel_addr[1:0];
          rdata_q      <= '0;
          err_q        <= misalign;
          waitcnt_q    <= '0;
          if (!misalign) begin
            read_q    <= ~sel_we;
            write_q   <= sel_we;
            address_q <= {sel_addr[31:2], 2'b00};
            be_q      <= sel_we ? la_be : BE_ALL;
            wdata_q   <= la_wdata;
          end
        end
        BUS: begin
          if (!bus.waitrequest) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            rdata_q <= we_q ? '0 : la_load;
          end else if (timeout) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            waitcnt_q <= waitcnt_q + CntW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = wdata_q;
  assign bus.byteenable = be_q;

endmodule

// File: tb/tb_mips_bus_mem_ctrl.sv
// Self-checking bench for mips_bus_mem_ctrl: directed cases plus randomized transactions.
module tb_mips_bus_mem_ctrl;

  localparam int unsigned MaxWait = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_signed, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  mips_bus_mem_ctrl_if bus_if ();

  mips_bus_mem_ctrl #(
    .ADDR_W   (32),
    .MAX_WAIT (MaxWait)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_size   (d_size),
    .d_signed (d_signed),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .bus      (bus_if),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input bit store, input logic [1:0] size,
                                          input logic [31:0] addr);
    if (!store || size >= 2'd2) return 4'hF;
    if (size == 2'd1) return addr[1] ? 4'hC : 4'h3;
    return 4'(32'd1 << addr[1:0]);
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (size == 2'd1) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input bit we, input logic [1:0] size, input bit sgn,
                                             input logic [31:0] addr, input logic [31:0] rd);
    int unsigned k;
    int unsigned v;
    k = 32'(addr[1:0]);
    if (we) return 32'd0;
    if (size == 2'd0) begin
      v = (rd >> (k * 8)) & 32'hFF;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (size == 2'd1) begin
      v = (rd >> ((k / 2) * 16)) & 32'hFFFF;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  // One complete transaction on channel ch (0 = fetch, 1 = data) with nwait stall cycles.
  task automatic run_txn(input string tag, input bit ch, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input bit sgn, input logic [31:0] wd,
                         input logic [31:0] rd, input int unsigned nwait);
    bit          store, mis, tmo;
    int unsigned nstb;
    logic [1:0]  sz;
    logic [31:0] exp_rd;
    store = ch && we;
    sz    = ch ? size : 2'd2;
    mis   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (sz == 2'd1) ? addr[0] : ((sz != 2'd0) && (addr[1:0] != 2'd0));
`endif
    tmo    = !mis && (nwait >= MaxWait);
    nstb   = mis ? 0 : (tmo ? MaxWait : nwait + 1);
    exp_rd = (mis || tmo) ? 32'd0 : (ch ? model_load(we, sz, sgn, addr, rd) : rd);
    if (ch) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_signed = sgn; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    bus_if.waitrequest = 1'b1;
    step();
    for (int unsigned c = 0; c < nstb; c++) begin
      bus_if.waitrequest = (c < nwait);
      bus_if.readdata    = (c < nwait) ? $urandom : rd;
      chk({tag, ".read"}, 32'(bus_if.read), 32'(!store));
      chk({tag, ".write"}, 32'(bus_if.write), 32'(store));
      chk({tag, ".address"}, bus_if.address, addr & 32'hFFFF_FFFC);
      chk({tag, ".be"}, 32'(bus_if.byteenable), 32'(model_be(store, sz, addr)));
      if (store) chk({tag, ".wdata"}, bus_if.writedata, model_wd(sz, wd));
      chk({tag, ".early_ack"}, 32'(if_ack | d_ack), 32'd0);
      step();
    end
    chk({tag, ".strobe_off"}, 32'(bus_if.read | bus_if.write), 32'd0);
    chk({tag, ".ack"}, {30'd0, d_ack, if_ack}, ch ? 32'd2 : 32'd1);
    chk({tag, ".rdata"}, ch ? d_rdata : if_rdata, exp_rd);
    chk({tag, ".err"}, 32'(ch ? d_err : if_err), 32'(mis || tmo));
    if_req = 1'b0;
    d_req  = 1'b0;
    step();
    chk({tag, ".ack_pulse"}, 32'(if_ack | d_ack), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_size = '0; d_signed = 1'b0; d_wdata = '0;
    bus_if.waitrequest = 1'b0;
    bus_if.readdata    = '0;
    step();
    step();
    chk("rst.address", bus_if.address, 32'd0);
    chk("rst.strobes", 32'(bus_if.read | bus_if.write), 32'd0);
    chk("rst.be", 32'(bus_if.byteenable), 32'd0);
    chk("rst.wdata", bus_if.writedata, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.outs", {if_rdata | d_rdata}, 32'd0);
    chk("rst.flags", {28'd0, if_ack, if_err, d_ack, d_err}, 32'd0);
    reset = 1'b1;
    step();

    // Tie after reset: data first, then the still-pending fetch.
    if_req = 1'b1; if_addr = 32'h0000_3000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4004; d_size = 2'd2; d_signed = 1'b0;
    bus_if.waitrequest = 1'b0; bus_if.readdata = 32'hA5A5_0001;
    step();
    chk("tie1.address", bus_if.address, 32'h0000_4004);
    chk("tie1.read", 32'(bus_if.read), 32'd1);
    step();
    chk("tie1.acks", {30'd0, d_ack, if_ack}, 32'd2);
    chk("tie1.rdata", d_rdata, 32'hA5A5_0001);
    d_req = 1'b0;
    step();
    bus_if.readdata = 32'h5A5A_0002;
    step();
    chk("tie1.fetch_address", bus_if.address, 32'h0000_3000);
    step();
    chk("tie1.fetch_acks", {30'd0, d_ack, if_ack}, 32'd1);
    chk("tie1.fetch_rdata", if_rdata, 32'h5A5A_0002);
    if_req = 1'b0;
    step();
    if_req = 1'b1; d_req = 1'b1; d_addr = 32'h0000_4008;
    step();
    chk("tie2.address", bus_if.address, 32'h0000_4008);
    step();
    chk("tie2.acks", {30'd0, d_ack, if_ack}, 32'd2);
    d_req = 1'b0;
    step();
    step();
    chk("tie2.fetch_address", bus_if.address, 32'h0000_3000);
    step();
    chk("tie2.fetch_acks", {30'd0, d_ack, if_ack}, 32'd1);
    if_req = 1'b0;
    step();

    run_txn("fetch", 1'b0, 1'b0, 32'h0000_1000, 2'd2, 1'b0, 32'd0, 32'hDEAD_BEEF, 0);
    run_txn("lb_s", 1'b1, 1'b0, 32'h0000_2003, 2'd0, 1'b1, 32'd0, 32'h8011_2233, 0);
    chk("lb_s.direct", 32'hFFFF_FF80, model_load(1'b0, 2'd0, 1'b1, 32'h2003, 32'h8011_2233));
    run_txn("lb_u", 1'b1, 1'b0, 32'h0000_2003, 2'd0, 1'b0, 32'd0, 32'h8011_2233, 0);
    run_txn("sh", 1'b1, 1'b1, 32'h0000_2002, 2'd1, 1'b0, 32'h0000_BEEF, 32'd0, 0);
    run_txn("wait3", 1'b1, 1'b0, 32'h0000_2000, 2'd2, 1'b0, 32'd0, 32'h1234_5678, 3);
    run_txn("tmo", 1'b1, 1'b0, 32'h0000_2000, 2'd2, 1'b0, 32'd0, 32'h1234_5678, 7);
    run_txn("lw_mis", 1'b1, 1'b0, 32'h0000_2001, 2'd2, 1'b0, 32'd0, 32'hCAFE_F00D, 0);
    run_txn("sb3", 1'b1, 1'b1, 32'h0000_2003, 2'd0, 1'b0, 32'h0000_00A7, 32'd0, 1);

    for (int i = 0; i < 40; i++) begin
      run_txn("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom_range(0, 5));
    end

    // Reset in the middle of a stalled read: strobe drops, no ack follows.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_5000; d_size = 2'd2; d_signed = 1'b0;
    bus_if.waitrequest = 1'b1;
    step();
    chk("mid.read", 32'(bus_if.read), 32'd1);
    reset = 1'b0;
    step();
    chk("mid.read_off", 32'(bus_if.read | bus_if.write), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.no_ack", 32'(if_ack | d_ack), 32'd0);
    d_req = 1'b0;
    reset = 1'b1;
    bus_if.waitrequest = 1'b0;
    step();
    chk("mid.no_ack2", 32'(if_ack | d_ack), 32'd0);
    if_req = 1'b1; if_addr = 32'h0000_6000; d_req = 1'b1; d_addr = 32'h0000_7000;
    step();
    chk("mid.tie_address", bus_if.address, 32'h0000_7000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
